// File: rtl/stack_context_ctrl.sv
// stack_context_ctrl: sequences interrupt context save/restore of r1..rNREGS
//   between the register file and the CPU hardware stack, and forwards single
//   CPU push/pop requests to the stack while idle.
// Latency: CPU push/pop forwarding and error pulses are combinational (zero
//   cycles); a save or restore runs for NREGS+1 busy cycles after the start.
// Backpressure: none on the stack side; the core must stall while busy is high,
//   because requests and starts arriving then are dropped silently.
//
// Ports:
//   clk, reset                   clock, asynchronous active-low reset
//   save_start, restore_start    sequence start pulses (save wins if both)
//   busy, done                   sequence running / last-cycle pulse
//   ovf_err, unf_err             refused push/save, refused pop/restore
//   cpu_push, cpu_pop, cpu_d     single-word CPU stack requests
//   rf_raddr, rf_rdata           register file read port (1-cycle read)
//   rf_we, rf_waddr, rf_wdata    register file write port
//   stk_push, stk_pop, stk_d     stack controls (this block is sole driver)
//   stk_q                        stack read data, valid the cycle after a pop
//
// Build option: define STACK_CTX_CHECK_EN to keep a mirror depth counter that
//   refuses overflowing pushes/saves and underflowing pops/restores. Without it
//   every request is accepted and ovf_err/unf_err stay 0.

module stack_context_ctrl #(
  parameter int NREGS = 15,
  parameter int DEPTH = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        save_start,
  input  logic        restore_start,
  output logic        busy,
  output logic        done,
  output logic        ovf_err,
  output logic        unf_err,
  input  logic        cpu_push,
  input  logic        cpu_pop,
  input  logic [31:0] cpu_d,
  output logic [3:0]  rf_raddr,
  input  logic [31:0] rf_rdata,
  output logic        rf_we,
  output logic [3:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic        stk_push,
  output logic        stk_pop,
  output logic [31:0] stk_d,
  input  logic [31:0] stk_q
);

  if (NREGS < 1 || NREGS > 15 || DEPTH < NREGS || DEPTH > 2047) begin : g_bad_params
    $error("stack_context_ctrl: NREGS must be 1..15 and DEPTH NREGS..2047");
  end

  typedef enum logic [2:0] {
    IDLE,
    SAVE,
    SAVE_TAIL,
    RESTORE,
    RESTORE_TAIL
  } state_t;

  localparam logic [3:0] LAST = 4'(NREGS);

  state_t     state;
  logic [3:0] cnt;

  // Acceptance qualifiers; all forced true when the depth checks are compiled out.
  logic pop_ok;
  logic push_ok;
  logic save_ok;
  logic restore_ok;

  logic start_save;
  logic start_restore;

`ifdef STACK_CTX_CHECK_EN
  localparam logic [10:0] CAP        = 11'(DEPTH);
  localparam logic [10:0] SAVE_LIMIT = 11'(DEPTH - NREGS);
  localparam logic [10:0] NREGS_D    = 11'(NREGS);

  logic [10:0] depth;
  logic [10:0] depth_idle;

  assign pop_ok  = (depth != 11'd0);
  assign push_ok = (depth != CAP);

  // Depth after this cycle's CPU op; sequence starts are judged against this
  // value so a pop in the same cycle as save_start can make room for the save.
  always_comb begin
    depth_idle = depth;
    if (cpu_pop) begin
      if (pop_ok) depth_idle = depth - 11'd1;
    end else if (cpu_push) begin
      if (push_ok) depth_idle = depth + 11'd1;
    end
  end

  assign save_ok    = (depth_idle <= SAVE_LIMIT);
  assign restore_ok = (depth_idle >= NREGS_D);

  // Sequences book their whole NREGS words on the final cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      depth <= '0;
    end else begin
      case (state)
        IDLE:         depth <= depth_idle;
        SAVE_TAIL:    depth <= depth + NREGS_D;
        RESTORE_TAIL: depth <= depth - NREGS_D;
        default:      depth <= depth;
      endcase
    end
  end
`else
  assign pop_ok     = 1'b1;
  assign push_ok    = 1'b1;
  assign save_ok    = 1'b1;
  assign restore_ok = 1'b1;
`endif

  always_comb begin
    busy          = (state != IDLE);
    done          = 1'b0;
    ovf_err       = 1'b0;
    unf_err       = 1'b0;
    stk_push      = 1'b0;
    stk_pop       = 1'b0;
    stk_d         = '0;
    rf_raddr      = '0;
    rf_we         = 1'b0;
    rf_waddr      = '0;
    rf_wdata      = '0;
    start_save    = 1'b0;
    start_restore = 1'b0;

    case (state)
      IDLE: begin
        // A simultaneous push and pop only considers the pop.
        if (cpu_pop) begin
          if (pop_ok) stk_pop = 1'b1;
          else        unf_err = 1'b1;
        end else if (cpu_push) begin
          if (push_ok) begin
            stk_push = 1'b1;
            stk_d    = cpu_d;
          end else begin
            ovf_err = 1'b1;
          end
        end

        if (save_start) begin
          if (save_ok) start_save = 1'b1;
          else         ovf_err    = 1'b1;
        end else if (restore_start) begin
          if (restore_ok) start_restore = 1'b1;
          else            unf_err       = 1'b1;
        end
      end

      // Read r(cnt) now, push r(cnt-1) whose read data has just arrived.
      SAVE: begin
        rf_raddr = cnt;
        if (cnt > 4'd1) begin
          stk_push = 1'b1;
          stk_d    = rf_rdata;
        end
      end

      SAVE_TAIL: begin
        stk_push = 1'b1;
        stk_d    = rf_rdata;
        done     = 1'b1;
      end

      // Pop for r(cnt), write r(cnt+1) from the previous cycle's pop.
      RESTORE: begin
        stk_pop = 1'b1;
        if (cnt < LAST) begin
          rf_we    = 1'b1;
          rf_waddr = cnt + 4'd1;
          rf_wdata = stk_q;
        end
      end

      RESTORE_TAIL: begin
        rf_we    = 1'b1;
        rf_waddr = 4'd1;
        rf_wdata = stk_q;
        done     = 1'b1;
      end

      default: begin
        busy = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start_save) begin
            state <= SAVE;
            cnt   <= 4'd1;
          end else if (start_restore) begin
            state <= RESTORE;
            cnt   <= LAST;
          end
        end
        SAVE: begin
          if (cnt == LAST) begin
            state <= SAVE_TAIL;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        SAVE_TAIL: begin
          state <= IDLE;
        end
        RESTORE: begin
          if (cnt == 4'd1) begin
            state <= RESTORE_TAIL;
            cnt   <= '0;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RESTORE_TAIL: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_stack_context_ctrl.sv
// Testbench for stack_context_ctrl with a behavioural stack and register file.
// Inputs change on the falling edge; outputs are sampled 2 time units later.
// Expectations that depend on the depth checks follow the STACK_CTX_CHECK_EN macro.

module tb_stack_context_ctrl;

`ifdef STACK_CTX_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        save_start, restore_start;
  logic        busy, done, ovf_err, unf_err;
  logic        cpu_push, cpu_pop;
  logic [31:0] cpu_d;
  logic [3:0]  rf_raddr, rf_waddr;
  logic [31:0] rf_rdata, rf_wdata;
  logic        rf_we;
  logic        stk_push, stk_pop;
  logic [31:0] stk_d, stk_q;

  stack_context_ctrl #(.NREGS(15), .DEPTH(1024)) dut (
    .clk(clk), .reset(reset),
    .save_start(save_start), .restore_start(restore_start),
    .busy(busy), .done(done), .ovf_err(ovf_err), .unf_err(unf_err),
    .cpu_push(cpu_push), .cpu_pop(cpu_pop), .cpu_d(cpu_d),
    .rf_raddr(rf_raddr), .rf_rdata(rf_rdata),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .stk_push(stk_push), .stk_pop(stk_pop), .stk_d(stk_d), .stk_q(stk_q)
  );

  always #5 clk = ~clk;

  // Behavioural stack and register file.
  logic [31:0] mem [0:2047];
  int          sp;
  logic [31:0] rf [0:15];

  int checks   = 0;
  int failures = 0;

  // Per-cycle samples and logs.
  logic        s_busy, s_done, s_ovf, s_unf, s_push, s_pop, s_we;
  logic [31:0] s_d, s_wdata;
  logic [3:0]  s_raddr, s_waddr;
  logic [31:0] push_log [$];
  logic [35:0] wr_log [$];
  int          busy_cnt, done_cnt, done_idx, pop_cnt;

  typedef struct {
    logic        push;
    logic        pop;
    logic [31:0] d;
    logic        e_push;
    logic        e_pop;
    logic        e_ovf;
    logic        e_unf;
  } vec_t;
  vec_t vt [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic clear_logs();
    push_log.delete();
    wr_log.delete();
    busy_cnt = 0;
    done_cnt = 0;
    done_idx = 0;
    pop_cnt  = 0;
  endtask

  task automatic idle_in();
    save_start    = 1'b0;
    restore_start = 1'b0;
    cpu_push      = 1'b0;
    cpu_pop       = 1'b0;
    cpu_d         = '0;
  endtask

  // One clock cycle: entered on a falling edge with inputs applied.
  task automatic tick();
    #2;
    s_busy = busy;  s_done = done;  s_ovf = ovf_err;  s_unf = unf_err;
    s_push = stk_push;  s_pop = stk_pop;  s_d = stk_d;
    s_we = rf_we;  s_waddr = rf_waddr;  s_wdata = rf_wdata;  s_raddr = rf_raddr;
    if (s_push) push_log.push_back(s_d);
    if (s_pop)  pop_cnt++;
    if (s_we)   wr_log.push_back({s_waddr, s_wdata});
    if (s_busy) busy_cnt++;
    if (s_done) begin
      done_cnt++;
      done_idx = busy_cnt;
    end
    @(posedge clk);
    #1;
    if (reset) begin
      rf_rdata = rf[s_raddr];
      if (s_we) rf[s_waddr] = s_wdata;
      if (s_push) begin
        mem[sp] = s_d;
        sp++;
      end else if (s_pop && sp > 0) begin
        sp--;
        stk_q = mem[sp];
      end
    end
    @(negedge clk);
  endtask

  task automatic run_seq(input string name);
    for (int i = 0; i < 40; i++) begin
      tick();
      if (!s_busy) break;
    end
    chk({name, "_ends"}, 32'(s_busy), 32'd0);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    idle_in();
    tick();
    tick();
    sp = 0;
    reset = 1'b1;
  endtask

  initial begin
    reset = 1'b0;
    idle_in();
    rf_rdata = '0;
    stk_q    = '0;
    sp       = 0;
    for (int i = 0; i < 16; i++) rf[i] = '0;
    clear_logs();

    vt[0] = '{push:1'b0, pop:1'b1, d:32'h0,         e_push:1'b0, e_pop:!CHK, e_ovf:1'b0, e_unf:CHK};
    vt[1] = '{push:1'b1, pop:1'b0, d:32'hA5A5_0001, e_push:1'b1, e_pop:1'b0, e_ovf:1'b0, e_unf:1'b0};
    vt[2] = '{push:1'b1, pop:1'b0, d:32'hA5A5_0002, e_push:1'b1, e_pop:1'b0, e_ovf:1'b0, e_unf:1'b0};
    vt[3] = '{push:1'b1, pop:1'b1, d:32'hDEAD_BEEF, e_push:1'b0, e_pop:1'b1, e_ovf:1'b0, e_unf:1'b0};
    vt[4] = '{push:1'b0, pop:1'b1, d:32'h0,         e_push:1'b0, e_pop:1'b1, e_ovf:1'b0, e_unf:1'b0};
    vt[5] = '{push:1'b0, pop:1'b1, d:32'h0,         e_push:1'b0, e_pop:!CHK, e_ovf:1'b0, e_unf:CHK};
    vt[6] = '{push:1'b1, pop:1'b1, d:32'h1234_5678, e_push:1'b0, e_pop:!CHK, e_ovf:1'b0, e_unf:CHK};
    vt[7] = '{push:1'b1, pop:1'b0, d:32'hB0B0_0007, e_push:1'b1, e_pop:1'b0, e_ovf:1'b0, e_unf:1'b0};

    // Reset state.
    @(negedge clk);
    #2;
    chk("rst_ctrl", 32'({busy, done, ovf_err, unf_err, stk_push, stk_pop, rf_we}), 32'd0);
    chk("rst_addr", 32'({rf_raddr, rf_waddr}), 32'd0);
    chk("rst_stk_d", stk_d, 32'd0);
    chk("rst_rf_wdata", rf_wdata, 32'd0);
    @(negedge clk);
    reset = 1'b1;

    // Idle CPU forwarding table.
    foreach (vt[i]) begin
      cpu_push = vt[i].push;
      cpu_pop  = vt[i].pop;
      cpu_d    = vt[i].d;
      tick();
      chk($sformatf("vec%0d_push", i), 32'(s_push), 32'(vt[i].e_push));
      chk($sformatf("vec%0d_pop", i),  32'(s_pop),  32'(vt[i].e_pop));
      chk($sformatf("vec%0d_ovf", i),  32'(s_ovf),  32'(vt[i].e_ovf));
      chk($sformatf("vec%0d_unf", i),  32'(s_unf),  32'(vt[i].e_unf));
      if (vt[i].e_push) chk($sformatf("vec%0d_d", i), s_d, vt[i].d);
    end
    idle_in();
    chk("vec_depth", 32'(sp), 32'd1);
    cpu_pop = 1'b1;
    tick();
    idle_in();
    chk("vec_drain_pop", 32'(s_pop), 32'd1);

    // Full context save.
    for (int i = 1; i < 16; i++) rf[i] = 32'h100 + 32'(i);
    clear_logs();
    save_start = 1'b1;
    tick();
    save_start = 1'b0;
    chk("save_start_busy", 32'(s_busy), 32'd0);
    run_seq("save");
    chk("save_npush", 32'(push_log.size()), 32'd15);
    for (int i = 0; i < 15 && i < push_log.size(); i++)
      chk($sformatf("save_data%0d", i), push_log[i], 32'h101 + 32'(i));
    chk("save_busy_cycles", 32'(busy_cnt), 32'd16);
    chk("save_done_cnt", 32'(done_cnt), 32'd1);
    chk("save_done_at", 32'(done_idx), 32'd16);
    chk("save_depth", 32'(sp), 32'd15);

    // Corrupt and restore.
    for (int i = 1; i < 16; i++) rf[i] = '0;
    clear_logs();
    restore_start = 1'b1;
    tick();
    restore_start = 1'b0;
    run_seq("restore");
    chk("rest_nwr", 32'(wr_log.size()), 32'd15);
    for (int i = 0; i < 15 && i < wr_log.size(); i++) begin
      chk($sformatf("rest_addr%0d", i), 32'(wr_log[i][35:32]), 32'(15 - i));
      chk($sformatf("rest_data%0d", i), wr_log[i][31:0], 32'h10F - 32'(i));
    end
    chk("rest_npop", 32'(pop_cnt), 32'd15);
    chk("rest_busy_cycles", 32'(busy_cnt), 32'd16);
    chk("rest_done_at", 32'(done_idx), 32'd16);
    chk("rest_depth", 32'(sp), 32'd0);
    for (int i = 1; i < 16; i++) chk($sformatf("rest_rf%0d", i), rf[i], 32'h100 + 32'(i));

`ifdef STACK_CTX_CHECK_EN
    // Restore refused at depth 14.
    cpu_push = 1'b1;
    for (int i = 0; i < 14; i++) begin
      cpu_d = 32'h2000 + 32'(i);
      tick();
    end
    idle_in();
    restore_start = 1'b1;
    tick();
    restore_start = 1'b0;
    chk("rest14_unf", 32'(s_unf), 32'd1);
    chk("rest14_nopop", 32'(s_pop), 32'd0);
    tick();
    chk("rest14_busy", 32'(s_busy), 32'd0);

    // Save refused at depth 1010, accepted when a same-cycle pop frees a word.
    cpu_push = 1'b1;
    for (int i = 0; i < 996; i++) begin
      cpu_d = 32'h3000 + 32'(i);
      tick();
    end
    idle_in();
    chk("fill_depth", 32'(sp), 32'd1010);
    save_start = 1'b1;
    tick();
    save_start = 1'b0;
    chk("save1010_ovf", 32'(s_ovf), 32'd1);
    tick();
    chk("save1010_busy", 32'(s_busy), 32'd0);
    clear_logs();
    save_start = 1'b1;
    cpu_pop    = 1'b1;
    tick();
    idle_in();
    chk("save1009_noovf", 32'(s_ovf), 32'd0);
    chk("save1009_pop", 32'(s_pop), 32'd1);
    run_seq("save_full");
    chk("save_full_npush", 32'(push_log.size()), 32'd15);
    chk("save_full_done", 32'(done_cnt), 32'd1);
    chk("save_full_depth", 32'(sp), 32'd1024);
    cpu_push = 1'b1;
    cpu_d    = 32'hFFFF_0000;
    tick();
    idle_in();
    chk("full_push_ovf", 32'(s_ovf), 32'd1);
    chk("full_push_blocked", 32'(s_push), 32'd0);
    chk("full_depth_kept", 32'(sp), 32'd1024);
`endif

    // Save and restore starts together at depth 20; CPU pushes while busy.
    do_reset();
    cpu_push = 1'b1;
    for (int i = 0; i < 20; i++) begin
      cpu_d = 32'h4000 + 32'(i);
      tick();
    end
    idle_in();
    clear_logs();
    save_start    = 1'b1;
    restore_start = 1'b1;
    tick();
    idle_in();
    chk("both_noerr", 32'({s_ovf, s_unf}), 32'd0);
    for (int i = 0; i < 16; i++) begin
      cpu_push = 1'b1;
      cpu_d    = 32'hBAD0_0000 + 32'(i);
      tick();
    end
    idle_in();
    tick();
    chk("both_idle_after", 32'(s_busy), 32'd0);
    chk("both_npush", 32'(push_log.size()), 32'd15);
    chk("both_nwr", 32'(wr_log.size()), 32'd0);
    if (push_log.size() == 15) begin
      chk("both_first", push_log[0], 32'h101);
      chk("both_last", push_log[14], 32'h10F);
    end
    chk("both_busy_cycles", 32'(busy_cnt), 32'd16);
    chk("both_depth", 32'(sp), 32'd35);

    // Reset on the fifth busy cycle of a save.
    do_reset();
    clear_logs();
    save_start = 1'b1;
    tick();
    save_start = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    #2;
    chk("mid_busy_pre", 32'(busy), 32'd1);
    reset = 1'b0;
    #1;
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_done", 32'(done), 32'd0);
    chk("mid_rst_push", 32'(stk_push), 32'd0);
    @(negedge clk);
    tick();
    sp = 0;
    reset = 1'b1;
    chk("mid_rst_no_done", 32'(done_cnt), 32'd0);
    cpu_pop = 1'b1;
    tick();
    idle_in();
    chk("post_rst_unf", 32'(s_unf), 32'(CHK));
    chk("post_rst_pop", 32'(s_pop), 32'(!CHK));
    clear_logs();
    save_start = 1'b1;
    tick();
    save_start = 1'b0;
    run_seq("save2");
    chk("save2_npush", 32'(push_log.size()), 32'd15);
    if (push_log.size() == 15) chk("save2_first", push_log[0], 32'h101);
    chk("save2_busy_cycles", 32'(busy_cnt), 32'd16);
    chk("save2_done_at", 32'(done_idx), 32'd16);
    chk("save2_depth", 32'(sp), 32'd15);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
